// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm scanner: truth-table geometry,
// counter width and the scanner FSM state encoding.
package minterm_pkg;

    localparam int NUM_VARS  = 4;
    localparam int TT_WIDTH  = 16;
    localparam int CNT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/tt_bit_select.sv
// Combinational 16:1 selector returning one bit of the latched truth table.
// Ports:
//   tt      - latched truth table
//   idx     - minterm number to look up
//   bit_out - tt[idx]
module tt_bit_select
    import minterm_pkg::*;
(
    input  logic [TT_WIDTH-1:0] tt,
    input  logic [NUM_VARS-1:0] idx,
    output logic                bit_out
);

    assign bit_out = tt[idx];

endmodule

// File: rtl/minterm_scanner.sv
// Streams the minterm list of a 4-variable function given as a truth table.
// Minterm numbers leave in ascending order over a valid/ready handshake.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   start     - scan request, only looked at in IDLE
//   tt        - truth table, bit i = F(i); latched when the scan starts
//   m_ready   - downstream accepts m_index
//   m_valid   - m_index holds a minterm number
//   m_index   - minterm number
//   busy      - scan in progress (start edge until DONE is entered)
//   done      - one-cycle pulse at scan end
//   count     - minterms emitted in the last or current scan (0..16)
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | testing latched_tt[idx]
// EMIT  | presenting idx as a minterm, waiting for m_ready
// DONE  | done pulse visible, returning to IDLE
module minterm_scanner
    import minterm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [TT_WIDTH-1:0]  tt,
    input  logic                 m_ready,
    output logic                 m_valid,
    output logic [NUM_VARS-1:0]  m_index,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] count
);

    state_t                state;
    logic [TT_WIDTH-1:0]   latched_tt;
    logic [NUM_VARS-1:0]   idx;
    logic                  cur_bit;

    tt_bit_select u_sel (
        .tt      (latched_tt),
        .idx     (idx),
        .bit_out (cur_bit)
    );

    // done and busy are set on the edge that enters DONE so both are
    // registered and the pulse is visible for the single DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            latched_tt <= '0;
            idx        <= '0;
            m_valid    <= 1'b0;
            m_index    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        latched_tt <= tt;
                        idx        <= '0;
                        count      <= '0;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_bit) begin
                        m_index <= idx;
                        m_valid <= 1'b1;
                        state   <= EMIT;
                    end else if (idx == 4'd15) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        count   <= count + 5'd1;
                        if (idx == 4'd15) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_scanner.sv
module tb_minterm_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] tt;
    logic        m_ready;
    logic        m_valid;
    logic [3:0]  m_index;
    logic        busy;
    logic        done;
    logic [4:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_q[$];
    int exp_done_q[$];

    always #5 clk = ~clk;

    minterm_scanner dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tt      (tt),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_index (m_index),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ones_of(input logic [15:0] t);
        int n = 0;
        for (int i = 0; i < 16; i++) if (t[i]) n++;
        return n;
    endfunction

    // Reference: the minterm list is every i whose truth-table bit is set,
    // in ascending order; count is the number of such i.
    task automatic push_model(input logic [15:0] t);
        for (int i = 0; i < 16; i++) if (t[i]) exp_q.push_back(i);
        exp_done_q.push_back(ones_of(t));
    endtask

    // Monitor: samples on the falling edge; inputs only change just after
    // the rising edge, so values seen here are the ones the next edge uses.
    initial begin : monitor
        logic       prev_valid = 1'b0;
        logic       prev_ready = 1'b0;
        logic [3:0] prev_index = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", int'(m_valid), 1);
                    check("hold_index", int'(m_index), int'(prev_index));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0)
                        check("unexpected_index", int'(m_index), -1);
                    else
                        check("m_index", int'(m_index), exp_q.pop_front());
                end
                if (done) begin
                    if (exp_done_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        check("done_count", int'(count), exp_done_q.pop_front());
                        check("stream_complete", exp_q.size(), 0);
                    end
                end
                prev_valid = m_valid;
                prev_ready = m_ready;
                prev_index = m_index;
            end
        end
    end

    // mode 0: m_ready=1, 1: random m_ready, 2: m_ready=1 plus restart attempt
    // and tt change while busy. stall_first: m_ready low for the first cycles.
    task automatic do_scan(input logic [15:0] t, input int mode,
                           input int stall_first, input int exp_lat);
        int lat = -1;
        push_model(t);
        start = 1'b1;
        tt    = t;
        @(posedge clk); #1;
        start = 1'b0;
        tt    = 16'($urandom);
        check("busy_after_start", int'(busy), 1);
        for (int n = 1; n <= 200; n++) begin
            if (n <= stall_first)  m_ready = 1'b0;
            else if (mode == 1)    m_ready = 1'($urandom_range(0, 1));
            else                   m_ready = 1'b1;
            if (mode == 2 && n == 3) begin
                start = 1'b1;
                tt    = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        if (lat < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            if (exp_lat >= 0) check("done_latency", lat, exp_lat);
            check("busy_cleared", int'(busy), 0);
            @(posedge clk); #1;
            check("done_one_cycle", int'(done), 0);
            check("count_held", int'(count), ones_of(t));
        end
        m_ready = 1'b0;
        if (mode == 2) begin
            repeat (5) @(posedge clk);
            #1;
            check("no_restart_busy", int'(busy), 0);
        end
    endtask

    task automatic rst_during_emit();
        logic [15:0] t = 16'h030B;
        int seen = 0;
        exp_q.push_back(0);
        exp_q.push_back(1);
        start = 1'b1;
        tt    = t;
        @(posedge clk); #1;
        start   = 1'b0;
        m_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (m_valid && m_index == 4'd3) begin
                seen = 1;
                break;
            end
        end
        check("reached_index3", seen, 1);
        m_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_index", int'(m_index), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(count), 0);
        repeat (4) @(posedge clk);
        #1;
        check("no_done_after_rst", int'(done), 0);
        check("rst_stream_consumed", exp_q.size(), 0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        tt      = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_m_valid", int'(m_valid), 0);
        check("reset_m_index", int'(m_index), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_count", int'(count), 0);
        // start together with rst: rst wins
        start = 1'b1;
        tt    = 16'hFFFF;
        @(posedge clk); #1;
        check("rst_over_start", int'(busy), 0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        do_scan(16'h030B, 0, 0, 16 + 5);
        do_scan(16'h0000, 0, 0, 16);
        do_scan(16'hFFFF, 0, 0, 32);
        do_scan(16'h8001, 0, 6, 16 + 2 + 5);
        do_scan(16'h0300, 2, 0, 16 + 2);
        rst_during_emit();
        do_scan(16'h030B, 0, 0, 16 + 5);

        for (int k = 0; k < 12; k++) begin
            logic [15:0] t = 16'($urandom);
            do_scan(t, 0, 0, 16 + ones_of(t));
        end
        for (int k = 0; k < 12; k++) begin
            logic [15:0] t = 16'($urandom);
            do_scan(t, 1, 0, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size() + exp_done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/minterm_scanner.md
MINTERM_SCANNER -- requirements
Module: minterm_scanner

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a scan; sampled only in IDLE.
REQ-005 SHALL have port tt, input, 16 bits: truth table of a 4-variable function; bit i = F(i), MSB variable = index bit 3.
REQ-006 SHALL have port m_ready, input, 1 bit: downstream accepts m_index.
REQ-007 SHALL have port m_valid, output, 1 bit: m_index holds a minterm number.
REQ-008 SHALL have port m_index, output, 4 bits: minterm number, emitted in ascending order.
REQ-009 SHALL have port busy, output, 1 bit: high from the edge sampling start until DONE is entered.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at scan end.
REQ-011 SHALL have port count, output, 5 bits: number of minterms emitted in the last or current scan, range 0..16.

Function
REQ-012 SHALL be the inverse of a sum-of-minterms implementation: given a truth table, stream the minterm list of the function.
REQ-013 SHALL implement the FSM states IDLE, SCAN, EMIT and DONE.
REQ-014 SHALL, in IDLE with start=1, latch tt, clear idx and count, set busy, and go to SCAN; tt changes after the latch SHALL be ignored.
REQ-015 SHALL, in SCAN with latched bit idx=1, register m_index=idx and m_valid=1, then go to EMIT.
REQ-016 SHALL, in SCAN with latched bit idx=0, go to DONE if idx=15; otherwise it SHALL increment idx and stay in SCAN.
REQ-017 SHALL, in EMIT, hold m_valid and m_index stable until m_ready=1.
REQ-018 SHALL, on the EMIT handshake edge, clear m_valid and increment count, then go to DONE if idx=15; otherwise it SHALL increment idx and go to SCAN.
REQ-019 SHALL, in DONE, assert done for exactly one cycle, clear busy, and return to IDLE.
REQ-020 SHALL take one edge per zero bit and two edges plus backpressure stall cycles per one bit.
REQ-021 SHALL ignore start while busy or in DONE, with no restart and no queuing.
REQ-022 SHALL ignore m_ready while m_valid=0.
REQ-023 SHALL not wrap idx; the scan terminates at 15.
REQ-024 SHALL report count=16 (5-bit width) for an all-ones table.
REQ-025 SHALL hold count after done until the next accepted start.
REQ-026 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-027 SHALL, with rst=1, force IDLE, m_valid=0, m_index=0, busy=0, done=0, count=0, idx=0 and latched table=0 at the next edge.
REQ-028 SHALL, when reset is asserted mid-scan (including in EMIT with m_valid=1), abandon the scan with no done pulse.
REQ-029 SHALL give rst priority over start when both are asserted on the same edge.

Structure
REQ-030 SHALL place NUM_VARS=4, TT_WIDTH=16, CNT_WIDTH=5 and the state encoding (IDLE, SCAN, EMIT, DONE) in the shared package minterm_pkg.
REQ-031 SHALL use a single sub-module, tt_bit_select: a combinational 16:1 selector of latched_tt[idx].
REQ-032 SHALL be 120-400 lines of RTL in total.

Verification
REQ-033 SHALL test tt=16'h030B with m_ready=1 and start for one cycle -> m_index stream 0,1,3,8,9, count=5, one done pulse.
REQ-034 SHALL test tt=16'h0000 with start -> no m_valid, done 16 edges after the start-sampling edge, count=0.
REQ-035 SHALL test tt=16'hFFFF with m_ready=1 -> indices 0..15 in order, done after 32 edges, count=16.
REQ-036 SHALL test tt=16'h8001 with m_ready held low for 5 cycles on index 0 -> m_index=0 held stable throughout, then 15 emitted, count=2.
REQ-037 SHALL test a second start pulse and a tt change while busy, with tt=16'h0300 -> the stream is still exactly 8,9 with a single done pulse.
REQ-038 SHALL test rst during EMIT of index 3 with tt=16'h030B -> next cycle all outputs 0 and no done pulse; a later start rescans from index 0.
